// File: rtl/rmt_alu_pkg.sv
// Definitions shared between the RMT load/store ALU and its key-value state memory:
// default widths, the memory's CLEAR/READY state encoding and the ALU opcodes.
package rmt_alu_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } kv_state_e;

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_ADDI  = 4'b1001;
    localparam logic [3:0] OP_SUBI  = 4'b1010;
    localparam logic [3:0] OP_STORE = 4'b1000;
    localparam logic [3:0] OP_LOAD  = 4'b1011;

endpackage

// File: rtl/kv_ram_1w1r.sv
// One-write/one-read register array. The read is registered once and a write to the
// address being read in the same cycle is forwarded (write-first).
module kv_ram_1w1r #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    // Array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Registered read with same-cycle write forwarding.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_q <= wr_data;
        end else begin
            rd_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/alu_kv_mem.sv
// Key-value state memory for one RMT action stage: store/cfg/clear write arbitration,
// CLEAR/READY sweep FSM and a 2-cycle fully pipelined load path.
module alu_kv_mem
    import rmt_alu_pkg::*;
#(
    parameter int STAGE_ID   = 0,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  store_en,
    input  logic [ADDR_WIDTH-1:0] store_addr,
    input  logic [DATA_WIDTH-1:0] store_din,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_valid,
    input  logic                  cfg_wr_en,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    output logic                  cfg_ready,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  store_drop
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    // STAGE_ID only tags the instance; a negative index would be a wiring mistake.
    if (STAGE_ID < 0) begin : g_stage_id_invalid
    end

    kv_state_e             state_q;
    logic [ADDR_WIDTH-1:0] clr_cnt_q;
    logic                  clr_busy_q;
    logic                  store_drop_q;

    logic                  wr_en_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic [DATA_WIDTH-1:0] rd_data_s;

    logic                  ld_v1_q;
    logic                  ld_zero1_q;
    logic                  load_valid_q;
    logic [DATA_WIDTH-1:0] load_data_q;

    // Single array write per cycle: sweep in CLEAR, otherwise store beats cfg.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = '0;
        wr_data_s = '0;
        if (state_q == ST_CLEAR) begin
            wr_en_s   = 1'b1;
            wr_addr_s = clr_cnt_q;
        end else if (store_en) begin
            wr_en_s   = 1'b1;
            wr_addr_s = store_addr;
            wr_data_s = store_din;
        end else if (cfg_wr_en) begin
            wr_en_s   = 1'b1;
            wr_addr_s = cfg_addr;
            wr_data_s = cfg_data;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    assign cfg_ready = (state_q == ST_READY) && !store_en;

    // CLEAR/READY sequencing; a clear request during a sweep is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            clr_busy_q   <= 1'b0;
            store_drop_q <= 1'b0;
        end else begin
            clr_busy_q   <= (state_q == ST_CLEAR);
            store_drop_q <= (state_q == ST_CLEAR) && store_en;
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (clr_req) begin
                        state_q   <= ST_CLEAR;
                        clr_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q   <= ST_CLEAR;
                    clr_cnt_q <= '0;
                end
            endcase
        end
    end

    kv_ram_1w1r #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_en_s),
        .wr_addr(wr_addr_s),
        .wr_data(wr_data_s),
        .rd_addr(load_addr),
        .rd_data(rd_data_s)
    );

    // Load pipeline; loads sampled in CLEAR are forced to zero at the output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_v1_q      <= 1'b0;
            ld_zero1_q   <= 1'b0;
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
        end else begin
            ld_v1_q      <= load_en;
            ld_zero1_q   <= (state_q == ST_CLEAR);
            load_valid_q <= ld_v1_q;
            if (ld_v1_q) begin
                load_data_q <= ld_zero1_q ? '0 : rd_data_s;
            end
        end
    end

    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign clr_busy   = clr_busy_q;
    assign store_drop = store_drop_q;

endmodule
